// File: rtl/tl_edge_pkg.sv
// TileLink-UL edge description shared by the A/D buffer: field widths,
// packed beat layouts and pack/unpack helpers.
package tl_edge_pkg;

  localparam int OPCODE_W  = 3;
  localparam int A_PARAM_W = 3;
  localparam int D_PARAM_W = 2;
  localparam int SIZE_W    = 3;
  localparam int SOURCE_W  = 5;
  localparam int ADDR_W    = 31;
  localparam int DATA_W    = 64;
  localparam int MASK_W    = 8;
  localparam int SINK_W    = 1;

  // Payload widths are the exact sum of the channel fields so every bit
  // of a beat is carried through the queue unchanged.
  localparam int A_PAYLOAD_W = OPCODE_W + A_PARAM_W + SIZE_W + SOURCE_W +
                               ADDR_W + MASK_W + DATA_W + 1;
  localparam int D_PAYLOAD_W = OPCODE_W + D_PARAM_W + SIZE_W + SOURCE_W +
                               SINK_W + 1 + DATA_W + 1;

  // A-channel beat, most significant field first.
  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic [A_PARAM_W-1:0] param;
    logic [SIZE_W-1:0]    size;
    logic [SOURCE_W-1:0]  source;
    logic [ADDR_W-1:0]    address;
    logic [MASK_W-1:0]    mask;
    logic [DATA_W-1:0]    data;
    logic                 corrupt;
  } tl_a_t;

  // D-channel beat, most significant field first.
  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic [D_PARAM_W-1:0] param;
    logic [SIZE_W-1:0]    size;
    logic [SOURCE_W-1:0]  source;
    logic [SINK_W-1:0]    sink;
    logic                 denied;
    logic [DATA_W-1:0]    data;
    logic                 corrupt;
  } tl_d_t;

  function automatic logic [A_PAYLOAD_W-1:0] pack_a(input tl_a_t beat);
    return beat;
  endfunction

  function automatic tl_a_t unpack_a(input logic [A_PAYLOAD_W-1:0] payload);
    return tl_a_t'(payload);
  endfunction

  function automatic logic [D_PAYLOAD_W-1:0] pack_d(input tl_d_t beat);
    return beat;
  endfunction

  function automatic tl_d_t unpack_d(input logic [D_PAYLOAD_W-1:0] payload);
    return tl_d_t'(payload);
  endfunction

endpackage

// File: rtl/tl_buffer_ad_if.sv
// One TileLink-UL A/D edge. The master modport is the client view
// (drives A, accepts D); the slave modport is the manager view.
//
// Handshake: a beat transfers on a rising clock edge where valid and
// ready are both 1. A source never waits for ready before raising valid,
// and once valid is high it and the payload hold until that transfer.
interface tl_buffer_ad_if;
  import tl_edge_pkg::*;

  logic                 a_valid;
  logic                 a_ready;
  logic [OPCODE_W-1:0]  a_bits_opcode;
  logic [A_PARAM_W-1:0] a_bits_param;
  logic [SIZE_W-1:0]    a_bits_size;
  logic [SOURCE_W-1:0]  a_bits_source;
  logic [ADDR_W-1:0]    a_bits_address;
  logic [MASK_W-1:0]    a_bits_mask;
  logic [DATA_W-1:0]    a_bits_data;
  logic                 a_bits_corrupt;

  logic                 d_valid;
  logic                 d_ready;
  logic [OPCODE_W-1:0]  d_bits_opcode;
  logic [D_PARAM_W-1:0] d_bits_param;
  logic [SIZE_W-1:0]    d_bits_size;
  logic [SOURCE_W-1:0]  d_bits_source;
  logic [SINK_W-1:0]    d_bits_sink;
  logic                 d_bits_denied;
  logic [DATA_W-1:0]    d_bits_data;
  logic                 d_bits_corrupt;

  modport master (
    output a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
           a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt,
    input  a_ready,
    input  d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
           d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt,
    output d_ready
  );

  modport slave (
    input  a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
           a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt,
    output a_ready,
    output d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
           d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt,
    input  d_ready
  );

endinterface

// File: rtl/tl_buf_queue.sv
// Registered FIFO used for one TileLink channel. Ready and valid come
// purely from internal state, so no combinational path crosses it.
module tl_buf_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_data
);

  // A one-entry queue still carries a 1-bit pointer that stays at zero.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             maybe_full;
  logic             ptr_match;
  logic             empty;
  logic             full;
  logic             do_enq;
  logic             do_deq;

  // Explicit wrap so non power-of-two depths cycle through 0..DEPTH-1.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Occupancy flags; full refuses an enqueue even if a dequeue is in flight.
  always_comb begin
    ptr_match = (wr_ptr == rd_ptr);
    empty     = ptr_match && !maybe_full;
    full      = ptr_match && maybe_full;
    enq_ready = !full;
    deq_valid = !empty;
    do_enq    = enq_valid && enq_ready;
    do_deq    = deq_valid && deq_ready;
    deq_data  = mem[rd_ptr];
  end

  // Storage array; left unreset since empty flags mask its contents.
  always_ff @(posedge clock) begin
    if (do_enq) begin
      mem[wr_ptr] <= enq_data;
    end
  end

  // Pointer and full-tracking state.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (do_enq) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_deq) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (do_enq != do_deq) begin
        maybe_full <= do_enq;
      end
    end
  end

endmodule

// File: rtl/tl_buffer_ad.sv
// Registered TileLink-UL A/D buffer: one queue per channel, fields packed
// into a flat beat on the way in and unpacked unchanged on the way out.
module tl_buffer_ad
  import tl_edge_pkg::*;
#(
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2
) (
  input  logic           clock,
  input  logic           reset,
  tl_buffer_ad_if.slave  auto_in,
  tl_buffer_ad_if.master auto_out
);

  tl_a_t                  a_in_beat;
  tl_a_t                  a_out_beat;
  tl_d_t                  d_in_beat;
  tl_d_t                  d_out_beat;
  logic [A_PAYLOAD_W-1:0] a_deq_payload;
  logic [D_PAYLOAD_W-1:0] d_deq_payload;

  // Gather the upstream A fields and the downstream D fields into beats.
  always_comb begin
    a_in_beat.opcode  = auto_in.a_bits_opcode;
    a_in_beat.param   = auto_in.a_bits_param;
    a_in_beat.size    = auto_in.a_bits_size;
    a_in_beat.source  = auto_in.a_bits_source;
    a_in_beat.address = auto_in.a_bits_address;
    a_in_beat.mask    = auto_in.a_bits_mask;
    a_in_beat.data    = auto_in.a_bits_data;
    a_in_beat.corrupt = auto_in.a_bits_corrupt;
    d_in_beat.opcode  = auto_out.d_bits_opcode;
    d_in_beat.param   = auto_out.d_bits_param;
    d_in_beat.size    = auto_out.d_bits_size;
    d_in_beat.source  = auto_out.d_bits_source;
    d_in_beat.sink    = auto_out.d_bits_sink;
    d_in_beat.denied  = auto_out.d_bits_denied;
    d_in_beat.data    = auto_out.d_bits_data;
    d_in_beat.corrupt = auto_out.d_bits_corrupt;
  end

  tl_buf_queue #(
    .WIDTH (A_PAYLOAD_W),
    .DEPTH (A_DEPTH)
  ) u_a_queue (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (auto_in.a_valid),
    .enq_ready (auto_in.a_ready),
    .enq_data  (pack_a(a_in_beat)),
    .deq_valid (auto_out.a_valid),
    .deq_ready (auto_out.a_ready),
    .deq_data  (a_deq_payload)
  );

  tl_buf_queue #(
    .WIDTH (D_PAYLOAD_W),
    .DEPTH (D_DEPTH)
  ) u_d_queue (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (auto_out.d_valid),
    .enq_ready (auto_out.d_ready),
    .enq_data  (pack_d(d_in_beat)),
    .deq_valid (auto_in.d_valid),
    .deq_ready (auto_in.d_ready),
    .deq_data  (d_deq_payload)
  );

  assign a_out_beat = unpack_a(a_deq_payload);
  assign d_out_beat = unpack_d(d_deq_payload);

  assign auto_out.a_bits_opcode  = a_out_beat.opcode;
  assign auto_out.a_bits_param   = a_out_beat.param;
  assign auto_out.a_bits_size    = a_out_beat.size;
  assign auto_out.a_bits_source  = a_out_beat.source;
  assign auto_out.a_bits_address = a_out_beat.address;
  assign auto_out.a_bits_mask    = a_out_beat.mask;
  assign auto_out.a_bits_data    = a_out_beat.data;
  assign auto_out.a_bits_corrupt = a_out_beat.corrupt;

  assign auto_in.d_bits_opcode   = d_out_beat.opcode;
  assign auto_in.d_bits_param    = d_out_beat.param;
  assign auto_in.d_bits_size     = d_out_beat.size;
  assign auto_in.d_bits_source   = d_out_beat.source;
  assign auto_in.d_bits_sink     = d_out_beat.sink;
  assign auto_in.d_bits_denied   = d_out_beat.denied;
  assign auto_in.d_bits_data     = d_out_beat.data;
  assign auto_in.d_bits_corrupt  = d_out_beat.corrupt;

endmodule

// File: tb/tb_tl_buffer_ad.sv
// Bench for tl_buffer_ad: directed steps followed by random traffic, all
// checked against bounded-capacity FIFO models of the A and D channels.
module tb_tl_buffer_ad;

  localparam int A_DEPTH = 2;
  localparam int D_DEPTH = 2;
  localparam int AW = 118;
  localparam int DW = 80;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  tl_buffer_ad_if in_if ();
  tl_buffer_ad_if out_if ();

  tl_buffer_ad #(
    .A_DEPTH (A_DEPTH),
    .D_DEPTH (D_DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .auto_in  (in_if),
    .auto_out (out_if)
  );

  // ---------------- model / scoreboard state ----------------
  logic [AW-1:0] exp_a_q[$];
  logic [DW-1:0] exp_d_q[$];
  logic [AW-1:0] a_src[$];
  logic [DW-1:0] d_src[$];
  int            idle_pct;
  int            n_vec;
  int            n_err;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] out_a_beat();
    return {out_if.a_bits_opcode, out_if.a_bits_param, out_if.a_bits_size,
            out_if.a_bits_source, out_if.a_bits_address, out_if.a_bits_mask,
            out_if.a_bits_data, out_if.a_bits_corrupt};
  endfunction

  function automatic logic [DW-1:0] out_d_beat();
    return {in_if.d_bits_opcode, in_if.d_bits_param, in_if.d_bits_size,
            in_if.d_bits_source, in_if.d_bits_sink, in_if.d_bits_denied,
            in_if.d_bits_data, in_if.d_bits_corrupt};
  endfunction

  function automatic logic [AW-1:0] mk_a(input logic [2:0] op, input logic [4:0] src,
                                          input logic [30:0] addr, input logic [7:0] mask,
                                          input logic [63:0] data);
    return {op, 3'd0, 3'd3, src, addr, mask, data, 1'b0};
  endfunction

  function automatic logic [DW-1:0] mk_d(input logic [2:0] op, input logic [2:0] size,
                                          input logic sink, input logic denied,
                                          input logic [63:0] data, input logic corrupt);
    return {op, 2'd0, size, 5'd9, sink, denied, data, corrupt};
  endfunction

  // Present the head of each source queue (with optional random idles).
  task automatic drive_sources();
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    pa = (a_src.size() > 0) ? a_src[0] : '0;
    pd = (d_src.size() > 0) ? d_src[0] : '0;
    in_if.a_valid = (a_src.size() > 0) && ($urandom_range(0, 99) >= idle_pct);
    {in_if.a_bits_opcode, in_if.a_bits_param, in_if.a_bits_size, in_if.a_bits_source,
     in_if.a_bits_address, in_if.a_bits_mask, in_if.a_bits_data, in_if.a_bits_corrupt} = pa;
    out_if.d_valid = (d_src.size() > 0) && ($urandom_range(0, 99) >= idle_pct);
    {out_if.d_bits_opcode, out_if.d_bits_param, out_if.d_bits_size, out_if.d_bits_source,
     out_if.d_bits_sink, out_if.d_bits_denied, out_if.d_bits_data, out_if.d_bits_corrupt} = pd;
  endtask

  // One clock: drive, check outputs against the model, advance the model.
  task automatic cycle();
    logic a_enq;
    logic a_deq;
    logic d_enq;
    logic d_deq;
    drive_sources();
    #1;
    chk("a_in_ready", in_if.a_ready, exp_a_q.size() < A_DEPTH);
    chk("a_out_valid", out_if.a_valid, exp_a_q.size() > 0);
    if (exp_a_q.size() > 0) chk("a_out_beat", out_a_beat(), exp_a_q[0]);
    chk("d_out_ready", out_if.d_ready, exp_d_q.size() < D_DEPTH);
    chk("d_in_valid", in_if.d_valid, exp_d_q.size() > 0);
    if (exp_d_q.size() > 0) chk("d_in_beat", out_d_beat(), exp_d_q[0]);
    a_enq = in_if.a_valid && (exp_a_q.size() < A_DEPTH);
    a_deq = out_if.a_ready && (exp_a_q.size() > 0);
    d_enq = out_if.d_valid && (exp_d_q.size() < D_DEPTH);
    d_deq = in_if.d_ready && (exp_d_q.size() > 0);
    @(posedge clock);
    if (reset) begin
      exp_a_q.delete();
      exp_d_q.delete();
    end else begin
      if (a_deq) void'(exp_a_q.pop_front());
      if (a_enq) exp_a_q.push_back(a_src.pop_front());
      if (d_deq) void'(exp_d_q.pop_front());
      if (d_enq) exp_d_q.push_back(d_src.pop_front());
    end
    @(negedge clock);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [127:0] r;
    n_vec = 0;
    n_err = 0;
    idle_pct = 0;
    reset = 1'b1;
    in_if.d_ready = 1'b1;
    out_if.a_ready = 1'b1;
    drive_sources();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_a_in_ready", in_if.a_ready, 1'b1);
    chk("rst_a_out_valid", out_if.a_valid, 1'b0);
    chk("rst_d_in_valid", in_if.d_valid, 1'b0);
    chk("rst_d_out_ready", out_if.d_ready, 1'b1);
    repeat (2) cycle();

    // Single Get, downstream always ready: out valid exactly one cycle later
    a_src.push_back(mk_a(3'd4, 5'd5, 31'h1000_0040, 8'hFF, 64'd0));
    cycle();
    chk("get_latency", out_if.a_valid, 1'b1);
    chk("get_beat", out_a_beat(), mk_a(3'd4, 5'd5, 31'h1000_0040, 8'hFF, 64'd0));
    cycle();
    chk("get_drained", out_if.a_valid, 1'b0);
    cycle();

    // Backpressure: three beats into a two-entry queue
    out_if.a_ready = 1'b0;
    a_src.push_back(mk_a(3'd0, 5'd1, 31'h100, 8'hFF, 64'h11));
    a_src.push_back(mk_a(3'd0, 5'd1, 31'h108, 8'hFF, 64'h22));
    a_src.push_back(mk_a(3'd0, 5'd1, 31'h110, 8'hFF, 64'h33));
    repeat (3) cycle();
    chk("bp_in_ready_low", in_if.a_ready, 1'b0);
    chk("bp_head_11", out_if.a_bits_data, 64'h11);
    out_if.a_ready = 1'b1;
    cycle();
    chk("bp_head_22", out_if.a_bits_data, 64'h22);
    cycle();
    chk("bp_head_33", out_if.a_bits_data, 64'h33);
    repeat (3) cycle();

    // Four-beat AccessAckData stream with both readies high
    for (int i = 0; i < 4; i++)
      d_src.push_back(mk_d(3'd1, 3'd5, i[0], i[1], 64'hA0 + 64'(i), i == 3));
    cycle();
    for (int i = 0; i < 4; i++) begin
      chk("d_stream_valid", in_if.d_valid, 1'b1);
      chk("d_stream_data", in_if.d_bits_data, 64'hA0 + 64'(i));
      cycle();
    end
    chk("d_stream_done", in_if.d_valid, 1'b0);

    // Full A queue with a dequeue in the same cycle: no bypass
    out_if.a_ready = 1'b0;
    a_src.push_back(mk_a(3'd1, 5'd2, 31'h200, 8'h0F, 64'h44));
    a_src.push_back(mk_a(3'd1, 5'd2, 31'h208, 8'hF0, 64'h55));
    repeat (2) cycle();
    a_src.push_back(mk_a(3'd1, 5'd2, 31'h210, 8'h3C, 64'h66));
    out_if.a_ready = 1'b1;
    chk("full_no_bypass", in_if.a_ready, 1'b0);
    cycle();
    chk("full_accept_next", in_if.a_ready, 1'b1);
    repeat (4) cycle();

    // Reset while the D queue holds two beats
    in_if.d_ready = 1'b0;
    d_src.push_back(mk_d(3'd0, 3'd3, 1'b1, 1'b0, 64'hDEAD, 1'b0));
    d_src.push_back(mk_d(3'd0, 3'd3, 1'b0, 1'b1, 64'hBEEF, 1'b1));
    repeat (3) cycle();
    chk("rst_mid_d_full", out_if.d_ready, 1'b0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_mid_d_valid", in_if.d_valid, 1'b0);
    chk("rst_mid_d_ready", out_if.d_ready, 1'b1);
    in_if.d_ready = 1'b1;
    repeat (3) cycle();

    // Random traffic on both channels
    idle_pct = 25;
    for (int n = 0; n < 600; n++) begin
      if (a_src.size() < 4 && $urandom_range(0, 1) == 1) begin
        r = {$urandom, $urandom, $urandom, $urandom};
        a_src.push_back(r[AW-1:0]);
      end
      if (d_src.size() < 4 && $urandom_range(0, 1) == 1) begin
        r = {$urandom, $urandom, $urandom, $urandom};
        d_src.push_back(r[DW-1:0]);
      end
      out_if.a_ready = ($urandom_range(0, 99) < 65);
      in_if.d_ready  = ($urandom_range(0, 99) < 65);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
